// File: rtl/truth_table_sweeper_pkg.sv
// Shared widths, FSM encoding and capture payload for the truth-table sweeper.
package truth_table_sweeper_pkg;

    localparam int unsigned NUM_PATTERNS = 16;
    localparam int unsigned PAT_W        = 4;
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned ONES_W       = 5;

    localparam logic [PAT_W-1:0] LAST_PATTERN = PAT_W'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Captured result: truth table bits plus running count of ones.
    typedef struct packed {
        logic [NUM_PATTERNS-1:0] bits;
        logic [ONES_W-1:0]       ones;
    } capture_t;

endpackage

// File: rtl/truth_table_sweeper_dwell_counter.sv
// Dwell timer: counts 0..DWELL-1 while enabled and flags the last cycle of a dwell.
module truth_table_sweeper_dwell_counter
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_c_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_c_o = (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_c_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 16 {A,B,C,D} patterns with a programmable dwell and captures F into a truth table.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    f_in,
    output logic                    A,
    output logic                    B,
    output logic                    C,
    output logic                    D,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_PATTERNS-1:0] table_out,
    output logic [ONES_W-1:0]       ones_count
);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] idx_q, idx_d;
    capture_t         cap_q, cap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             dwell_end_c;

    truth_table_sweeper_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cnt_clr),
        .en_i    (cnt_en),
        .tc_c_o  (dwell_end_c)
    );

    // Next-state and datapath update; F is sampled on the last cycle of each dwell.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    cap_d   = '0;
                    busy_d  = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                cnt_en = 1'b1;
                if (dwell_end_c) begin
                    cap_d.bits[idx_q] = f_in;
                    cap_d.ones        = cap_q.ones + ONES_W'(f_in);
                    idx_d             = idx_q + PAT_W'(1);
                    if (idx_q == LAST_PATTERN) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign {A, B, C, D} = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign table_out    = cap_q.bits;
    assign ones_count   = cap_q.ones;

endmodule
